// File: rtl/core_mem_lsu.sv
// RV32I load/store unit with a tightly coupled single-port data RAM.

module sp_ram_data #(
  parameter int DEPTH     = 8,
  parameter int AW        = $clog2(DEPTH),
  parameter     INIT_FILE = "../data/dataMem_h.mem"
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_data [0:DEPTH-1];

  localparam string unused_init_file = INIT_FILE;

  // Byte-enabled write; contents are deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_data[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_data[addr];
endmodule

module core_mem_lsu #(
  parameter int DEPTH     = 8,
  parameter     INIT_FILE = "../data/dataMem_h.mem"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        misaligned_o
);
  localparam int AW = $clog2(DEPTH);

  logic          accept_s;
  logic          legal_s;
  logic [3:0]    be_s;
  logic [31:0]   wlane_s;
  logic          ram_we_s;
  logic [31:0]   ram_rdata_s;
  logic [31:0]   rdata_r;
  logic          rvalid_r;
  logic          misaligned_r;
  logic          unused_addr_s;

  assign unused_addr_s = ^addr_i[31:AW+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v = word[8*off +: 8];
    half_v = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{byte_v[7]}}, byte_v};
      3'b001:  load_extend = {{16{half_v[15]}}, half_v};
      3'b100:  load_extend = {24'h000000, byte_v};
      3'b101:  load_extend = {16'h0000, half_v};
      default: load_extend = word;
    endcase
  endfunction

  assign accept_s = req_i & ~stall_i;

  // Decode width code into legality, byte enables and lane-replicated store data
  always_comb begin
    legal_s = 1'b0;
    be_s    = 4'b0000;
    wlane_s = 32'h0000_0000;
    case (funct3_i)
      3'b000: begin
        legal_s = 1'b1;
        be_s    = 4'b0001 << addr_i[1:0];
        wlane_s = {4{wdata_i[7:0]}};
      end
      3'b001: begin
        legal_s = ~addr_i[0];
        be_s    = addr_i[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_i[15:0]}};
      end
      3'b010: begin
        legal_s = (addr_i[1:0] == 2'b00);
        be_s    = 4'b1111;
        wlane_s = wdata_i;
      end
      3'b100: begin
        legal_s = ~we_i;
      end
      3'b101: begin
        legal_s = ~we_i & ~addr_i[0];
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // A store coinciding with reset assertion must not reach the RAM
  assign ram_we_s = accept_s & we_i & legal_s & rst_n;

  sp_ram_data #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) sp_ram_data_i (
    .clk   (clk),
    .we    (ram_we_s),
    .be    (be_s),
    .addr  (addr_i[AW+1:2]),
    .wdata (wlane_s),
    .rdata (ram_rdata_s)
  );

  // Registered load result and one-cycle status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r      <= 32'h0000_0000;
      rvalid_r     <= 1'b0;
      misaligned_r <= 1'b0;
    end else if (accept_s) begin
      if (!legal_s) begin
        rvalid_r     <= 1'b0;
        misaligned_r <= 1'b1;
      end else if (!we_i) begin
        rdata_r      <= load_extend(ram_rdata_s, funct3_i, addr_i[1:0]);
        rvalid_r     <= 1'b1;
        misaligned_r <= 1'b0;
      end else begin
        rvalid_r     <= 1'b0;
        misaligned_r <= 1'b0;
      end
    end else begin
      rvalid_r     <= 1'b0;
      misaligned_r <= 1'b0;
    end
  end

  assign rdata_o      = rdata_r;
  assign rvalid_o     = rvalid_r;
  assign misaligned_o = misaligned_r;
endmodule

// File: tb/tb_core_mem_lsu.sv
// Randomised bench for core_mem_lsu against a byte-level behavioural model.
module tb_core_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] rdata;
  logic        rvalid;
  logic        misaligned;

  int vectors = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [31:0] model_mem [0:7];
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_rvalid = 1'b0;
  logic        exp_mis = 1'b0;
  int          m_idx, m_off, m_size;
  logic [31:0] m_val;

  core_mem_lsu #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
    .rdata_o(rdata), .rvalid_o(rvalid), .misaligned_o(misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: byte-wise memory plus expected output state
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_rdata = 32'h0; exp_rvalid = 1'b0; exp_mis = 1'b0;
    end else if (req && !stall) begin
      m_idx = int'(addr[4:2]);
      m_off = int'(addr[1:0]);
      case (f3)
        3'd0, 3'd4: m_size = 1;
        3'd1, 3'd5: m_size = 2;
        3'd2:       m_size = 4;
        default:    m_size = 0;
      endcase
      if (m_size == 0 || (we && f3[2]) || (m_off % m_size) != 0) begin
        exp_mis = 1'b1; exp_rvalid = 1'b0;
      end else if (we) begin
        for (int k = 0; k < m_size; k++)
          model_mem[m_idx][8*(m_off+k) +: 8] = wdata[8*k +: 8];
        exp_mis = 1'b0; exp_rvalid = 1'b0;
      end else begin
        m_val = 32'h0;
        for (int k = 0; k < m_size; k++)
          m_val[8*k +: 8] = model_mem[m_idx][8*(m_off+k) +: 8];
        if (!f3[2] && m_size < 4 && m_val[8*m_size-1])
          for (int k = m_size; k < 4; k++) m_val[8*k +: 8] = 8'hFF;
        exp_rdata = m_val; exp_rvalid = 1'b1; exp_mis = 1'b0;
      end
    end else begin
      exp_rvalid = 1'b0; exp_mis = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      vectors++;
      if (rdata !== exp_rdata || rvalid !== exp_rvalid || misaligned !== exp_mis) begin
        errors++;
        $display("FAIL model t=%0t: got rdata=%h rvalid=%b mis=%b, expected rdata=%h rvalid=%b mis=%b",
                 $time, rdata, rvalid, misaligned, exp_rdata, exp_rvalid, exp_mis);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic op(input logic r, input logic w, input logic [2:0] f,
                    input logic [31:0] a, input logic [31:0] d, input logic s);
    req = r; we = w; f3 = f; addr = a; wdata = d; stall = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = 32'hA5A5_0000 + i;
    model_mem[0] = 32'h1122_3344;
    model_mem[1] = 32'h80FF_7F01;
    for (int i = 0; i < 8; i++) dut.sp_ram_data_i.mem_data[i] = model_mem[i];

    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;
    check("reset_rdata", rdata, 32'h0);
    check("reset_flags", {30'h0, rvalid, misaligned}, 32'h0);
    @(posedge clk); #1;
    cmp_en = 1'b1;

    op(1, 0, 3'b010, 32'h0, 32'h0, 0); check("lw0", rdata, 32'h1122_3344);
    check("lw0_valid", {31'h0, rvalid}, 32'h1);
    op(1, 0, 3'b000, 32'h3, 32'h0, 0); check("lb3", rdata, 32'h0000_0011);
    op(1, 0, 3'b000, 32'h6, 32'h0, 0); check("lb6", rdata, 32'hFFFF_FFFF);
    op(1, 0, 3'b100, 32'h6, 32'h0, 0); check("lbu6", rdata, 32'h0000_00FF);
    op(1, 0, 3'b001, 32'h6, 32'h0, 0); check("lh6", rdata, 32'hFFFF_80FF);
    op(1, 0, 3'b101, 32'h6, 32'h0, 0); check("lhu6", rdata, 32'h0000_80FF);
    op(1, 1, 3'b000, 32'h1, 32'h0000_00AB, 0);
    check("sb_no_valid", {31'h0, rvalid}, 32'h0);
    op(1, 0, 3'b010, 32'h0, 32'h0, 0); check("sb_lw0", rdata, 32'h1122_AB44);
    op(1, 1, 3'b001, 32'h6, 32'h0000_BEEF, 0);
    op(1, 0, 3'b010, 32'h4, 32'h0, 0); check("sh_lw4", rdata, 32'hBEEF_7F01);

    for (int i = 0; i < 3; i++) begin
      op(1, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, 1);
      check("stall_mem", dut.sp_ram_data_i.mem_data[2], 32'hA5A5_0002);
      check("stall_pulses", {30'h0, rvalid, misaligned}, 32'h0);
    end
    op(1, 1, 3'b010, 32'h8, 32'hDEAD_BEEF, 0);
    check("stall_release", dut.sp_ram_data_i.mem_data[2], 32'hDEAD_BEEF);
    op(1, 0, 3'b010, 32'h8, 32'h0, 0); check("raw_lw8", rdata, 32'hDEAD_BEEF);

    op(1, 0, 3'b010, 32'h2, 32'h0, 0);
    check("mis_lw2", {30'h0, rvalid, misaligned}, 32'h1);
    op(0, 0, 3'b000, 32'h0, 32'h0, 0);
    check("mis_pulse_end", {31'h0, misaligned}, 32'h0);
    op(1, 1, 3'b001, 32'h5, 32'h0000_1234, 0);
    check("mis_sh5", {30'h0, rvalid, misaligned}, 32'h1);
    check("mis_sh5_mem", dut.sp_ram_data_i.mem_data[1], 32'hBEEF_7F01);
    op(1, 0, 3'b010, 32'h20, 32'h0, 0); check("wrap_lw20", rdata, 32'h1122_AB44);

    for (int i = 0; i < 1500; i++) begin
      op(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
         3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    op(1, 0, 3'b010, 32'h0, 32'h0, 0);
    check("pre_reset_valid", {31'h0, rvalid}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'h0);
    check("async_rst_flags", {30'h0, rvalid, misaligned}, 32'h0);
    op(1, 1, 3'b010, 32'h0, 32'hCAFE_F00D, 0);
    op(1, 1, 3'b010, 32'h4, 32'hCAFE_F00D, 0);
    req = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) check("mem_after_reset", dut.sp_ram_data_i.mem_data[i], model_mem[i]);
    op(0, 0, 3'b000, 32'h0, 32'h0, 0);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
